instr_fetch_ctrl: RTL and testbench
===================================

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 100: number of instruction words; valid fetch addresses are 0..MEM_DEPTH-1.
REQ-002 Parameter RESET_PC, default 0: word address fetched first after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 run  input  1  start fetching when in IDLE.
REQ-006 imem_addr  output  32  word address driven to the instruction memory; equals pc.
REQ-007 imem_data  input  32  combinational instruction word at imem_addr, valid in the same cycle.
REQ-008 redirect  input  1  taken branch from execute (BEZ/BNE); one-cycle pulse.
REQ-009 redirect_target  input  32  word address to fetch after a redirect.
REQ-010 ir  output  32  instruction register presented to decode.
REQ-011 ir_pc  output  32  word address the instruction in ir was fetched from.
REQ-012 ir_valid  output  1  ir holds an instruction for decode.
REQ-013 ir_ready  input  1  decode accepts ir this cycle (transfer when ir_valid & ir_ready).
REQ-014 fault  output  1  pc outside 0..MEM_DEPTH-1; fetching suspended.
REQ-015 fetch_count  output  32  number of completed ir transfers since reset, wraps modulo 2^32.

Function
REQ-016 States IDLE, RUN, FAULT; IDLE->RUN on run=1; RUN->FAULT when pc >= MEM_DEPTH (unsigned) and a load would occur; FAULT->RUN on redirect with in-range target.
REQ-017 In RUN, a load occurs when (!ir_valid | ir_ready) & !redirect & pc < MEM_DEPTH: ir<=imem_data, ir_pc<=pc, ir_valid<=1.
REQ-018 Latency: word at address A appears on ir exactly one cycle after imem_addr=A is loaded.
REQ-019 Next pc on a load: if imem_data[31:26]=101010 (JMP), pc<=pc+sign_extend(imem_data[15:0]); otherwise pc<=pc+1; all arithmetic 32-bit modulo 2^32.
REQ-020 JMP words are still delivered on ir; decode treats them as no-ops; no bubble follows a JMP.
REQ-021 Stall: ir_valid & !ir_ready holds ir, ir_pc, ir_valid and pc unchanged.
REQ-022 Redirect (any state except IDLE) has priority over load, stall and JMP: pc<=redirect_target, ir_valid<=0 next cycle, held instruction discarded.
REQ-023 Redirect and transfer in the same cycle: transfer counts in fetch_count, then flush per REQ-022.
REQ-024 Entering FAULT: fault<=1, no further loads; ir_valid keeps its value until transferred or flushed.
REQ-025 FAULT exit via redirect to out-of-range target remains in FAULT.
REQ-026 In IDLE: no loads, ir_valid=0, redirect ignored.
REQ-027 fetch_count increments by 1 on every cycle with ir_valid & ir_ready.

Reset
REQ-028 While rst=1, immediately: state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, fault=0, fetch_count=0.
REQ-029 Reset asserted mid-stall or mid-redirect discards all in-flight state; no transfer is counted in that cycle.

Structure
REQ-030 Shared package cpu_isa_pkg SHALL hold OP_JMP=101010, OP_BEZ=101000, OP_BNE=101001, opcode field [31:26], immediate field [15:0] and the state enumeration.
REQ-031 One sub-module, fetch_next_pc: combinational pc, instruction -> next pc (JMP detect, sign extension, add).

Verification
REQ-032 Sequential: memory 0..4 non-JMP, run=1, ir_ready=1 -> ir_pc 0,1,2,3,4 on consecutive cycles, fetch_count=5.
REQ-033 JMP loop: mem[0]=JMP +3, mem[4]=JMP -3 (imm 0xFFFD) -> ir_pc sequence 0,3,4,1,2,3,4,1,...
REQ-034 Stall: ir_ready=0 for 3 cycles at ir_pc=2 -> ir, ir_pc, imem_addr=3 stable, fetch_count unchanged; resumes with ir_pc=3.
REQ-035 Redirect during stall at ir_pc=5, target 20 -> ir_valid=0 next cycle, then ir_pc=20; instruction 5 never counted.
REQ-036 Fault: mem[98]=JMP +5 -> pc=103, fault=1, no loads; redirect target 7 -> fault=0, ir_pc=7 next.
REQ-037 Async reset asserted mid-cycle during RUN -> all outputs at REQ-028 values before next clock edge.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared ISA definitions for the fetch stage: opcode encodings, instruction
// field positions and the fetch controller state enumeration.
package cpu_isa_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned IMM_W      = IMM_MSB - IMM_LSB + 1;

  localparam logic [5:0] OP_JMP = 6'b101010;
  localparam logic [5:0] OP_BEZ = 6'b101000;
  localparam logic [5:0] OP_BNE = 6'b101001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [XLEN-1:0] imm_sext(input logic [XLEN-1:0] instr);
    return {{(XLEN-IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
  endfunction

  function automatic logic is_jmp(input logic [XLEN-1:0] instr);
    return opcode_of(instr) == OP_JMP;
  endfunction

  // Conditional branches are resolved in execute and arrive as redirects.
  function automatic logic is_cond_branch(input logic [XLEN-1:0] instr);
    return (opcode_of(instr) == OP_BEZ) || (opcode_of(instr) == OP_BNE);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_fetch_next_pc.sv
// Combinational next-pc for the fetch stage: unconditional JMP words add
// their sign-extended immediate, everything else advances by one word.
module fetch_next_pc
  import cpu_isa_pkg::*;
(
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_next_pc
);

  logic            w_is_jmp;
  logic [XLEN-1:0] w_offset;

  always_comb begin
    w_is_jmp  = is_jmp(i_instr);
    w_offset  = w_is_jmp ? imm_sext(i_instr) : {{(XLEN-1){1'b0}}, 1'b1};
    o_next_pc = i_pc + w_offset;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory address, loads
// the instruction register with a valid/ready handshake, follows JMP words
// locally and accepts taken-branch redirects from execute.
module instr_fetch_ctrl
  import cpu_isa_pkg::*;
#(
  parameter int unsigned     MEM_DEPTH = 100,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic            fault,
  output logic [XLEN-1:0] fetch_count
);

  localparam logic [XLEN-1:0] DEPTH_W = XLEN'(MEM_DEPTH);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_ir_pc;
  logic            r_ir_valid;
  logic            r_fault;
  logic [XLEN-1:0] r_fetch_count;

  logic [XLEN-1:0] w_next_pc;
  logic            w_xfer;
  logic            w_slot_free;
  logic            w_pc_ok;
  logic            w_tgt_ok;

  fetch_next_pc u_next_pc (
    .i_pc      (r_pc),
    .i_instr   (imem_data),
    .o_next_pc (w_next_pc)
  );

  assign w_xfer      = r_ir_valid & ir_ready;
  assign w_slot_free = ~r_ir_valid | ir_ready;
  assign w_pc_ok     = r_pc < DEPTH_W;
  assign w_tgt_ok    = redirect_target < DEPTH_W;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_ir          <= '0;
      r_ir_pc       <= '0;
      r_ir_valid    <= 1'b0;
      r_fault       <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      // A transfer is counted even when a redirect flushes ir in the same cycle.
      if (w_xfer) begin
        r_fetch_count <= r_fetch_count + 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (redirect) begin
            r_pc       <= redirect_target;
            r_ir_valid <= 1'b0;
          end else if (w_slot_free) begin
            if (w_pc_ok) begin
              r_ir       <= imem_data;
              r_ir_pc    <= r_pc;
              r_ir_valid <= 1'b1;
              r_pc       <= w_next_pc;
            end else begin
              // Slot free implies any held instruction is transferring now.
              r_state    <= ST_FAULT;
              r_fault    <= 1'b1;
              r_ir_valid <= 1'b0;
            end
          end
        end

        ST_FAULT: begin
          if (redirect) begin
            r_pc       <= redirect_target;
            r_ir_valid <= 1'b0;
            if (w_tgt_ok) begin
              r_state <= ST_RUN;
              r_fault <= 1'b0;
            end
          end else if (w_xfer) begin
            r_ir_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign ir_valid    = r_ir_valid;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios with literal
// expectations plus a randomized run compared against a reference model.
module tb_instr_fetch_ctrl;

  localparam int unsigned DEPTH = 100;
  localparam int unsigned MSZ   = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        redirect;
  logic        ir_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] redirect_target;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic [31:0] fetch_count;
  logic        ir_valid;
  logic        fault;

  logic [31:0] mem [MSZ];

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < MSZ) ? mem[imem_addr[6:0]] : 32'h0;

  instr_fetch_ctrl #(.MEM_DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .ir              (ir),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .fault           (fault),
    .fetch_count     (fetch_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 fetching, 2 faulted.
  int          m_mode;
  logic [31:0] m_pc, m_ir, m_irpc, m_cnt;
  bit          m_v, m_fault;

  task automatic model_reset();
    m_mode = 0; m_pc = 32'd0; m_ir = 32'd0; m_irpc = 32'd0;
    m_cnt = 32'd0; m_v = 0; m_fault = 0;
  endtask

  task automatic model_edge();
    bit          xfer, room;
    logic [31:0] w;
    xfer = m_v && ir_ready;
    room = !m_v || ir_ready;
    if (xfer) m_cnt = m_cnt + 32'd1;
    if (m_mode == 0) begin
      if (run) m_mode = 1;
    end else if (redirect) begin
      m_pc = redirect_target;
      m_v  = 0;
      if (m_mode == 2 && redirect_target < DEPTH) begin
        m_mode = 1; m_fault = 0;
      end
    end else if (m_mode == 1 && room) begin
      if (m_pc < DEPTH) begin
        w      = mem[m_pc[6:0]];
        m_ir   = w;
        m_irpc = m_pc;
        m_v    = 1;
        if (w[31:26] == 6'b101010) m_pc = m_pc + 32'($signed(w[15:0]));
        else                       m_pc = m_pc + 32'd1;
      end else begin
        m_mode = 2; m_fault = 1; m_v = 0;
      end
    end else if (xfer) begin
      m_v = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_edge();
    end
  end

  // Every cycle out of reset: DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        chk("imem_addr",   imem_addr,   m_pc);
        chk("ir_valid",    {31'd0, ir_valid}, {31'd0, m_v});
        chk("fault",       {31'd0, fault},    {31'd0, m_fault});
        chk("fetch_count", fetch_count, m_cnt);
        chk("ir",          ir,          m_ir);
        chk("ir_pc",       ir_pc,       m_irpc);
      end
    end
  end

  // Record completed transfers as sampled at the active edge.
  logic [31:0] xq [$];
  initial begin
    forever begin
      @(posedge clk);
      if (rst === 1'b0 && ir_valid && ir_ready) xq.push_back(ir_pc);
    end
  end

  task automatic nxt();
    @(negedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_addr"},   imem_addr,   32'd0);
    chk({tag, "_ir"},          ir,          32'd0);
    chk({tag, "_ir_pc"},       ir_pc,       32'd0);
    chk({tag, "_ir_valid"},    {31'd0, ir_valid}, 32'd0);
    chk({tag, "_fault"},       {31'd0, fault},    32'd0);
    chk({tag, "_fetch_count"}, fetch_count, 32'd0);
  endtask

  task automatic do_reset();
    run = 0; redirect = 0; ir_ready = 0; redirect_target = 32'd0;
    rst = 1;
    model_reset();
    #1;
    check_reset_values("rst");
    nxt();
    rst = 0;
    xq.delete();
  endtask

  task automatic fill_seq();
    for (int i = 0; i < MSZ; i++) mem[i] = 32'h0100_0000 + 32'(i);
  endtask

  task automatic wait_xq(input int n);
    int k = 0;
    while (xq.size() < n && k < 200) begin
      nxt();
      k++;
    end
    chk("xfer_wait", 32'(xq.size()), 32'(n));
  endtask

  task automatic wait_irpc(input logic [31:0] pc);
    int k = 0;
    while (!(ir_valid && ir_pc == pc) && k < 200) begin
      nxt();
      k++;
    end
    chk("irpc_wait", ir_pc, pc);
  endtask

  logic [31:0] exp_jmp [8];

  initial begin
    rst = 1;
    fill_seq();

    // Sequential fetch
    do_reset();
    run = 1; ir_ready = 1;
    wait_xq(5);
    ir_ready = 0;
    chk("seq_count", fetch_count, 32'd5);
    for (int i = 0; i < 5; i++) chk("seq_irpc", xq[i], 32'(i));

    // JMP loop
    fill_seq();
    mem[0] = {6'b101010, 10'd0, 16'd3};
    mem[4] = {6'b101010, 10'd0, 16'hFFFD};
    exp_jmp = '{32'd0, 32'd3, 32'd4, 32'd1, 32'd2, 32'd3, 32'd4, 32'd1};
    do_reset();
    run = 1; ir_ready = 1;
    wait_xq(8);
    ir_ready = 0;
    for (int i = 0; i < 8; i++) chk("jmp_irpc", xq[i], exp_jmp[i]);

    // Stall at ir_pc=2, then redirect during stall at ir_pc=5
    fill_seq();
    do_reset();
    run = 1; ir_ready = 1;
    wait_irpc(32'd2);
    ir_ready = 0;
    chk("stall_cnt0", fetch_count, 32'd2);
    for (int i = 0; i < 3; i++) begin
      nxt();
      chk("stall_irpc", ir_pc, 32'd2);
      chk("stall_ir",   ir,    32'h0100_0002);
      chk("stall_addr", imem_addr, 32'd3);
      chk("stall_cnt",  fetch_count, 32'd2);
    end
    ir_ready = 1;
    nxt();
    chk("resume_irpc", ir_pc, 32'd3);
    chk("resume_cnt",  fetch_count, 32'd3);
    wait_irpc(32'd5);
    ir_ready = 0; redirect = 1; redirect_target = 32'd20;
    nxt();
    redirect = 0;
    chk("redir_valid", {31'd0, ir_valid}, 32'd0);
    chk("redir_cnt",   fetch_count, 32'd5);
    chk("redir_addr",  imem_addr, 32'd20);
    ir_ready = 1;
    nxt();
    chk("redir_irpc",  ir_pc, 32'd20);
    chk("redir_valid2", {31'd0, ir_valid}, 32'd1);

    // Fault via JMP past the end of memory
    fill_seq();
    mem[98] = {6'b101010, 10'd0, 16'd5};
    do_reset();
    run = 1; ir_ready = 1;
    nxt();
    redirect = 1; redirect_target = 32'd98;
    nxt();
    redirect = 0;
    begin
      int k = 0;
      while (!fault && k < 20) begin nxt(); k++; end
    end
    chk("fault_set",   {31'd0, fault}, 32'd1);
    chk("fault_addr",  imem_addr, 32'd103);
    chk("fault_irpc",  ir_pc, 32'd98);
    nxt(); nxt();
    chk("fault_hold",  {31'd0, fault}, 32'd1);
    chk("fault_nold",  {31'd0, ir_valid}, 32'd0);
    redirect = 1; redirect_target = 32'd7;
    nxt();
    redirect = 0;
    chk("fault_clr",   {31'd0, fault}, 32'd0);
    nxt();
    chk("fault_exit_irpc", ir_pc, 32'd7);

    // Async reset mid-cycle while running
    nxt(); nxt();
    rst = 1;
    #1;
    check_reset_values("async");
    nxt();
    rst = 0;

    // Randomized run against the model
    for (int i = 0; i < MSZ; i++) begin
      logic [31:0] w;
      int          s;
      w = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        s = int'($urandom_range(0, 16)) - 8;
        w = {6'b101010, w[25:16], 16'(s)};
      end
      mem[i] = w;
    end
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      run             = ($urandom_range(0, 9) != 0);
      ir_ready        = ($urandom_range(0, 9) < 7);
      redirect        = ($urandom_range(0, 11) == 0);
      redirect_target = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(100, 140))
                                                    : 32'($urandom_range(0, 99));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1;
        #1;
        check_reset_values("rnd_rst");
        nxt();
        rst = 0;
      end else begin
        nxt();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
